crank_signal_decoder: RTL

Turns the raw crank trigger-wheel pulse train (N-M wheel) and the cam pulse into the per-tooth `crank_changed` pulse, the stroke-boundary `crank_tick` pulse and the `ckp` phase level consumed by the stroke state machine. It sits between the sensor input pins and stroke sequencing. It measures tooth periods, finds the missing-tooth gap, verifies one full revolution before declaring sync, and drops sync on any tooth-count or stall fault.

---
 rtl/crank_signal_decoder_pkg.sv | 26 ++
 rtl/crank_signal_decoder_edge_sync.sv | 32 +++
 rtl/crank_signal_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/crank_signal_decoder_pkg.sv
// Shared constants and types for the crank signal decoder.
//   - decoder state encodings
//   - default wheel geometry and period counter width
//   - packed bundle of the decoder's registered single-bit outputs
package crank_signal_decoder_pkg;

    localparam int unsigned DEF_TOOTH_NUM = 36;
    localparam int unsigned DEF_MISSING   = 1;
    localparam int unsigned DEF_CNT_W     = 24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEEK_GAP = 2'd1,
        ST_VERIFY   = 2'd2,
        ST_SYNCED   = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic crank_changed;
        logic crank_tick;
        logic ckp;
        logic synced;
        logic sync_error;
    } dec_out_t;

endpackage

// File: rtl/crank_signal_decoder_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   din          : asynchronous input
//   rise         : one-cycle pulse, 2 cycles after the first edge sampling din high
module crank_signal_decoder_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 resynchronise din; s3 is the previous synchronised value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
            rise <= s2_q & ~s3_q;
        end
    end

endmodule

// File: rtl/crank_signal_decoder.sv
// Crank trigger-wheel decoder for an N-M wheel plus cam phase input.
// Measures tooth periods, locates the missing-tooth gap, verifies one full
// revolution before declaring sync and drops sync on tooth-count or stall faults.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   on            : enable; low forces IDLE and clears everything
//   crank_in      : raw crank sensor pulse (asynchronous)
//   cam_in        : raw cam sensor pulse (asynchronous, once per 720 deg)
//   crank_changed : one-cycle pulse per valid tooth while synced
//   crank_tick    : one-cycle pulse at tooth_idx 0 and HALF_IDX
//   ckp           : revolution phase, 1 = intake/compression revolution
//   synced        : position valid
//   tooth_idx     : current tooth index, 0 = first tooth after the gap
//   sync_error    : one-cycle pulse on sync loss or failed verification
module crank_signal_decoder
    import crank_signal_decoder_pkg::*;
#(
    parameter int unsigned TOOTH_NUM   = DEF_TOOTH_NUM,
    parameter int unsigned MISSING     = DEF_MISSING,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned STALL_LIMIT = 32'h00FF_FFFF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         on,
    input  logic                         crank_in,
    input  logic                         cam_in,
    output logic                         crank_changed,
    output logic                         crank_tick,
    output logic                         ckp,
    output logic                         synced,
    output logic [$clog2(TOOTH_NUM)-1:0] tooth_idx,
    output logic                         sync_error
);

    localparam int unsigned IDX_W    = $clog2(TOOTH_NUM);
    localparam int unsigned LAST_IDX = TOOTH_NUM - MISSING - 1;
    localparam int unsigned HALF_IDX = TOOTH_NUM / 2;

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             cam_seen_q, cam_seen_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    dec_out_t         out_q, out_d;

    logic             crank_rise;
    logic             cam_rise;
    logic [CNT_W:0]   gap_thr;
    logic             gap_edge;
    logic             at_last;
    logic             stall;
    logic             cam_now;

    crank_signal_decoder_edge_sync u_crank_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (crank_in),
        .rise    (crank_rise)
    );

    crank_signal_decoder_edge_sync u_cam_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (cam_in),
        .rise    (cam_rise)
    );

    // 1.5x previous period, one bit wider so the sum cannot overflow.
    assign gap_thr  = {1'b0, prev_q} + {2'b00, prev_q[CNT_W-1:1]};
    assign gap_edge = crank_rise && prev_valid_q && ({1'b0, cnt_q} > gap_thr);
    assign at_last  = (idx_q == IDX_W'(LAST_IDX));
    assign stall    = (cnt_q == CNT_W'(STALL_LIMIT));
    // A cam edge in the same cycle as a gap edge belongs to that gap.
    assign cam_now  = cam_seen_q | cam_rise;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cam_seen_q   <= 1'b0;
            idx_q        <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cam_seen_q   <= cam_seen_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
        end
    end

    // Next-state, period measurement and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        cam_seen_d   = cam_now;
        idx_d        = idx_q;
        out_d        = '0;
        out_d.ckp    = out_q.ckp;
        out_d.synced = out_q.synced;

        // Saturating period counter, restarted by every crank edge.
        if (crank_rise) begin
            prev_d = cnt_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d        = '0;
                prev_d       = '0;
                prev_valid_d = 1'b0;
                cam_seen_d   = 1'b0;
                idx_d        = '0;
                out_d        = '0;
                state_d      = ST_SEEK_GAP;
            end

            ST_SEEK_GAP: begin
                if (crank_rise) begin
                    prev_valid_d = 1'b1;
                    if (gap_edge) begin
                        idx_d   = '0;
                        state_d = ST_VERIFY;
                    end
                end else if (stall) begin
                    prev_valid_d = 1'b0;
                end
            end

            ST_VERIFY: begin
                if (crank_rise) begin
                    if (gap_edge && at_last) begin
                        idx_d               = '0;
                        state_d             = ST_SYNCED;
                        out_d.synced        = 1'b1;
                        out_d.crank_changed = 1'b1;
                        out_d.crank_tick    = 1'b1;
                        out_d.ckp           = cam_now;
                        cam_seen_d          = 1'b0;
                    end else if (gap_edge || at_last) begin
                        state_d          = ST_SEEK_GAP;
                        out_d.sync_error = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (stall) begin
                    state_d          = ST_SEEK_GAP;
                    prev_valid_d     = 1'b0;
                    out_d.sync_error = 1'b1;
                end
            end

            ST_SYNCED: begin
                if (crank_rise) begin
                    if (gap_edge && at_last) begin
                        idx_d               = '0;
                        out_d.crank_changed = 1'b1;
                        out_d.crank_tick    = 1'b1;
                        out_d.ckp           = cam_now ? 1'b1 : ~out_q.ckp;
                        cam_seen_d          = 1'b0;
                    end else if (gap_edge || at_last) begin
                        // Faulting edge: no crank_changed, phase held.
                        state_d          = ST_SEEK_GAP;
                        prev_valid_d     = 1'b0;
                        out_d.synced     = 1'b0;
                        out_d.sync_error = 1'b1;
                    end else begin
                        idx_d               = idx_q + IDX_W'(1);
                        out_d.crank_changed = 1'b1;
                        out_d.crank_tick    = (idx_q == IDX_W'(HALF_IDX - 1));
                    end
                end else if (stall) begin
                    state_d          = ST_SEEK_GAP;
                    prev_valid_d     = 1'b0;
                    out_d.synced     = 1'b0;
                    out_d.sync_error = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Disable wins over everything.
        if (!on) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            prev_d       = '0;
            prev_valid_d = 1'b0;
            cam_seen_d   = 1'b0;
            idx_d        = '0;
            out_d        = '0;
        end
    end

    assign crank_changed = out_q.crank_changed;
    assign crank_tick    = out_q.crank_tick;
    assign ckp           = out_q.ckp;
    assign synced        = out_q.synced;
    assign sync_error    = out_q.sync_error;
    assign tooth_idx     = idx_q;

endmodule
